regfile_mp: RTL

- Parametrised multi-read-port integer register file for the single-cycle/pipelined core. It is the successor to the current 2-read/1-write file.
- Adds configurable read-port count and a sequential zero-clear after reset with a ready flag.
- Adds a per-register busy scoreboard for the upcoming pipelined datapath and a dedicated return-value tap for the halt path.
- Sits between decode (read addresses, busy marks) and writeback (write port).

---
 rtl/regfile_mp.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp -- parametrised multi-read-port integer register file
//
// A register file with NR_READ combinational read ports and one write port.
// After every reset the array is zeroed one entry per clock. init_done goes
// high once the last entry has been cleared. A per-register busy scoreboard
// tracks pending producers for the pipelined datapath. halt_ret exposes
// rf[RET_REG] directly for the halt path.
//
// Parameters:
//   ADDR_WIDTH  register index width (depth = 2**ADDR_WIDTH)
//   DATA_WIDTH  register width
//   NR_READ     number of combinational read ports (1..4)
//   RET_REG     register index exported on halt_ret
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   wen        in   write enable
//   waddr      in   write index
//   wdata      in   write data
//   raddr      in   packed read indices, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   rdata      out  packed read data, same packing as raddr
//   rbusy      out  busy flag of each read port's register
//   busy_set   in   mark busy_addr as pending
//   busy_addr  in   register to mark busy
//   init_done  out  high once the post-reset clear has completed
//   halt_ret   out  current value of rf[RET_REG]
//
// Build option:
//   REGFILE_BYPASS_EN  when defined, same-cycle write data and the resulting
//                      busy state are forwarded to the read ports and to
//                      halt_ret. When undefined, reads return the pre-edge
//                      array contents.
// -----------------------------------------------------------------------------
module regfile_mp #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NR_READ    = 2,
  parameter int RET_REG    = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wen,
  input  logic [ADDR_WIDTH-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0]         wdata,
  input  logic [NR_READ*ADDR_WIDTH-1:0] raddr,
  output logic [NR_READ*DATA_WIDTH-1:0] rdata,
  output logic [NR_READ-1:0]            rbusy,
  input  logic                          busy_set,
  input  logic [ADDR_WIDTH-1:0]         busy_addr,
  output logic                          init_done,
  output logic [DATA_WIDTH-1:0]         halt_ret
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] RET_IDX = ADDR_WIDTH'(RET_REG);

  typedef enum logic {CLEAR, READY} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] clr_idx;
  logic [DATA_WIDTH-1:0] rf [DEPTH];
  logic [DEPTH-1:0]      busy, busy_nxt;

  // Array write port: the clear sequence and the normal write share it.
  logic                  rf_we;
  logic [ADDR_WIDTH-1:0] rf_wa;
  logic [DATA_WIDTH-1:0] rf_wd;
  logic                  sb_set, sb_clr;

  logic ready;
  logic clr_last;
  logic wr_hit_ok;  // a real, non-x0 write is happening this cycle

  assign ready     = (state == READY);
  assign clr_last  = (clr_idx == '1);
  assign wr_hit_ok = ready && wen && (waddr != '0);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of the order the blocks are evaluated.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLEAR;
      init_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      init_done <= (state_nxt == READY);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    if (state == CLEAR && clr_last) state_nxt = READY;
  end

  // ---------------------------------------------------------------------------
  // FSM: output / datapath control
  // ---------------------------------------------------------------------------
  always_comb begin
    rf_we  = 1'b0;
    rf_wa  = clr_idx;
    rf_wd  = '0;
    sb_set = 1'b0;
    sb_clr = 1'b0;
    case (state)
      CLEAR: begin
        rf_we = 1'b1;
      end
      READY: begin
        rf_we  = wen && (waddr != '0);
        rf_wa  = waddr;
        rf_wd  = wdata;
        sb_set = busy_set && (busy_addr != '0);
        sb_clr = wen;
      end
      default: ;
    endcase
  end

  // The clear index walks through the array only while clearing. It is held
  // at 0 during reset and wraps back to 0 after the last entry.
  always_ff @(posedge clk) begin
    if (rst)                 clr_idx <= '0;
    else if (state == CLEAR) clr_idx <= clr_idx + 1'b1;
  end

  // NOTE: the array itself has no reset term. It is zeroed by the sequential
  // clear, which keeps it mappable onto RAM/flop arrays without a wide reset
  // fan-out. rst only blocks the write so that no in-flight write lands.
  always_ff @(posedge clk) begin
    if (!rst && rf_we) rf[rf_wa] <= rf_wd;
  end

  // Scoreboard: the clear is applied before the set, so a set to the same
  // index on the same edge wins.
  always_comb begin
    busy_nxt = busy;
    if (sb_clr) busy_nxt[waddr]     = 1'b0;
    if (sb_set) busy_nxt[busy_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  // ---------------------------------------------------------------------------
  // Combinational read ports
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < NR_READ; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] rd;
    logic                  rb;

    assign ra = raddr[i*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      rd = rf[ra];
      rb = busy[ra];
`ifdef REGFILE_BYPASS_EN
      if (wr_hit_ok && ra == waddr) begin
        rd = wdata;
        rb = busy_set && (busy_addr == waddr);
      end
`endif
      if (!ready || ra == '0) begin
        rd = '0;
        rb = 1'b0;
      end
    end

    assign rdata[i*DATA_WIDTH +: DATA_WIDTH] = rd;
    assign rbusy[i]                          = rb;
  end

  // Return-value tap for the halt path.
  always_comb begin
    halt_ret = rf[RET_IDX];
`ifdef REGFILE_BYPASS_EN
    if (wr_hit_ok && waddr == RET_IDX) halt_ret = wdata;
`endif
    if (!ready || RET_IDX == '0) halt_ret = '0;
  end

`ifndef REGFILE_BYPASS_EN
  // Without forwarding the write-hit qualifier has no reader.
  logic unused_wr_hit;
  assign unused_wr_hit = wr_hit_ok;
`endif

endmodule
